// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared FSM states, frame constants and abort codes for the UART command assembler
package uart_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_PAYLOAD, S_CHECK, S_HOLD} state_t;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int FRAME_LEN = 11;
  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_OP = 2'b11;
endpackage

// File: rtl/byte_timeout_timer.sv
// byte_timeout_timer: counts idle cycles while enabled, flags expiry on the last allowed cycle
module byte_timeout_timer #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = CYCLES > 2 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  assign expired = enable && cnt == W'(CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + W'(1) : cnt;
endmodule

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: parses HEADER/OP/A/B/CHK byte frames into a 66-bit command with error reporting
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [65:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        overrun
);
  localparam logic [2:0] LAST = 3'(FRAME_LEN - 4);
  state_t st, st_n;
  logic [1:0] op_q;
  logic [63:0] pay_q;
  logic [7:0] chk_q;
  logic [2:0] cnt_q;
  logic expired, abort, tmr_en;
  logic [1:0] code;
  assign tmr_en = st == S_OPCODE || st == S_PAYLOAD || st == S_CHECK;
  assign cmd_valid = st == S_HOLD;
  byte_timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .clk(clk),
    .reset(reset),
    .clear(rx_valid || !tmr_en),
    .enable(tmr_en),
    .expired(expired)
  );
  always_comb begin
    st_n = st;
    abort = 1'b0;
    code = 2'b00;
    case (st)
      S_IDLE: st_n = rx_valid && rx_data == HEADER ? S_OPCODE : S_IDLE;
      S_OPCODE:
        if (rx_valid) begin
          st_n = rx_data[7:2] == 6'd0 ? S_PAYLOAD : S_IDLE;
          abort = rx_data[7:2] != 6'd0;
          code = ERR_OP;
        end
      S_PAYLOAD: st_n = rx_valid && cnt_q == LAST ? S_CHECK : S_PAYLOAD;
      S_CHECK:
        if (rx_valid) begin
          st_n = rx_data == chk_q ? S_HOLD : S_IDLE;
          abort = rx_data != chk_q;
          code = ERR_CHK;
        end
      S_HOLD: st_n = cmd_ready ? S_IDLE : S_HOLD;
      default: st_n = S_IDLE;
    endcase
    // a byte arriving on the expiry cycle wins over the timeout
    if (expired && !rx_valid) begin
      st_n = S_IDLE;
      abort = 1'b1;
      code = ERR_TMO;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_IDLE;
      op_q <= '0;
      pay_q <= '0;
      chk_q <= '0;
      cnt_q <= '0;
      cmd_word <= '0;
      frame_err <= 1'b0;
      err_code <= '0;
      overrun <= 1'b0;
    end else begin
      st <= st_n;
      frame_err <= abort;
      overrun <= rx_valid && st == S_HOLD;
      if (abort) err_code <= code;
      if (rx_valid && st == S_OPCODE) begin
        op_q <= rx_data[1:0];
        chk_q <= rx_data;
        cnt_q <= '0;
      end
      if (rx_valid && st == S_PAYLOAD) begin
        pay_q <= {pay_q[55:0], rx_data};
        chk_q <= chk_q ^ rx_data;
        cnt_q <= cnt_q + 3'd1;
      end
      if (st == S_CHECK && st_n == S_HOLD) cmd_word <= {pay_q[31:0], pay_q[63:32], op_q};
    end
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: table vectors, corner sequences and randomized frames against a queue-based frame model
module tb_uart_cmd_assembler;
  import uart_cmd_pkg::*;
  localparam int TMO = 16;
  localparam logic [7:0] HDR = 8'hA5;
  typedef struct {
    logic v;
    logic [7:0] d;
    logic r;
    logic ev;
    logic ee;
    logic [1:0] ec;
    logic eo;
  } vec_t;
  logic clk = 0, reset = 0, rx_valid = 0, cmd_ready = 0;
  logic [7:0] rx_data = 0;
  logic [65:0] cmd_word;
  logic cmd_valid, frame_err, overrun;
  logic [1:0] err_code;
  int checks = 0, failures = 0;
  logic [7:0] fq[$];
  logic [7:0] tx[$];
  vec_t tbl[$];
  int idle = 0;
  logic m_hold = 0, m_err = 0, m_ovr = 0;
  logic [65:0] m_word = 0;
  logic [1:0] m_code = 0;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(TMO), .HEADER(HDR)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_word(cmd_word),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .frame_err(frame_err),
    .err_code(err_code),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [65:0] a, input logic [65:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h req=%h", n, a, e);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    idle = 0;
    m_hold = 0;
    m_word = 0;
    m_err = 0;
    m_ovr = 0;
    m_code = 0;
  endtask

  task automatic model_abort(input logic [1:0] c);
    m_err = 1;
    m_code = c;
    fq.delete();
  endtask

  // frame-level model: a queue of received frame bytes plus an idle-cycle count
  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic [7:0] x;
    m_err = 0;
    m_ovr = 0;
    if (m_hold) begin
      m_ovr = v;
      if (r) m_hold = 0;
    end else if (v) begin
      idle = 0;
      if (fq.size() != 0 || d == HDR) fq.push_back(d);
      if (fq.size() == 2 && d[7:2] != 0) model_abort(2'b11);
      else if (fq.size() == 11) begin
        x = 0;
        for (int i = 1; i <= 9; i++) x ^= fq[i];
        if (x == fq[10]) begin
          m_hold = 1;
          m_word = {fq[6], fq[7], fq[8], fq[9], fq[2], fq[3], fq[4], fq[5], fq[1][1:0]};
          fq.delete();
        end else model_abort(2'b01);
      end
    end else if (fq.size() != 0) begin
      idle++;
      if (idle == TMO) model_abort(2'b10);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v;
    rx_data = d;
    cmd_ready = r;
    model_step(v, d, r);
    @(posedge clk);
    #1;
    chk("cmd_valid", 66'(cmd_valid), 66'(m_hold));
    chk("cmd_word", cmd_word, m_word);
    chk("frame_err", 66'(frame_err), 66'(m_err));
    chk("err_code", 66'(err_code), 66'(m_code));
    chk("overrun", 66'(overrun), 66'(m_ovr));
    rx_valid = 0;
  endtask

  task automatic build(input logic [7:0] opb, input logic [31:0] a, input logic [31:0] b, input logic bad);
    logic [7:0] x;
    tx.delete();
    tx.push_back(HDR);
    tx.push_back(opb);
    x = opb;
    for (int i = 3; i >= 0; i--) begin
      tx.push_back(a[8*i+:8]);
      x ^= a[8*i+:8];
    end
    for (int i = 3; i >= 0; i--) begin
      tx.push_back(b[8*i+:8]);
      x ^= b[8*i+:8];
    end
    tx.push_back(bad ? ~x : x);
  endtask

  task automatic send(input int gap, input logic r);
    foreach (tx[i]) begin
      cycle(1, tx[i], r);
      if (i != tx.size() - 1) repeat (gap) cycle(0, 8'h00, r);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (m_hold && n < 40) begin
      cycle($urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
      n++;
    end
    if (m_hold) cycle(0, 8'h00, 1);
    chk("drain_valid", 66'(cmd_valid), 66'(0));
  endtask

  task automatic do_reset();
    rx_valid = 0;
    cmd_ready = 0;
    reset = 0;
    #1;
    chk("rst_valid", 66'(cmd_valid), 66'(0));
    chk("rst_word", cmd_word, 66'(0));
    chk("rst_err", 66'(frame_err), 66'(0));
    chk("rst_code", 66'(err_code), 66'(0));
    chk("rst_ovr", 66'(overrun), 66'(0));
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    logic [7:0] gf[11];
    logic [31:0] a, b;
    logic [7:0] opb;
    int kind, k, first, ovn, gap;
    gf = '{8'hA5, 8'h00, 8'h40, 8'hA0, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'hE0};
    for (int i = 0; i < 11; i++) tbl.push_back('{1'b1, gf[i], 1'b0, i == 10, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0});
    repeat (3) @(posedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_valid", 66'(cmd_valid), 66'(tbl[i].ev));
      chk("tbl_err", 66'(frame_err), 66'(tbl[i].ee));
      chk("tbl_code", 66'(err_code), 66'(tbl[i].ec));
      chk("tbl_ovr", 66'(overrun), 66'(tbl[i].eo));
    end
    chk("good_word", cmd_word, {32'h40400000, 32'h40A00000, 2'b00});
    chk("badop_idle", 66'(dut.st), 66'(S_IDLE));

    build(8'h00, 32'h40A00000, 32'h40400000, 0);
    tx[10] = 8'hFF;
    send(0, 0);
    chk("badchk_err", 66'(frame_err), 66'(1));
    chk("badchk_code", 66'(err_code), 66'(2'b01));
    chk("badchk_valid", 66'(cmd_valid), 66'(0));
    build(8'h01, 32'h12345678, 32'h9ABCDEF0, 0);
    send(1, 0);
    chk("after_bad_valid", 66'(cmd_valid), 66'(1));
    chk("after_bad_word", cmd_word, {32'h9ABCDEF0, 32'h12345678, 2'b01});
    cycle(0, 8'h00, 1);

    cycle(1, HDR, 0);
    cycle(1, 8'h01, 0);
    cycle(1, 8'h41, 0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 8'h00, 0);
      if (frame_err && first == 0) first = i;
    end
    chk("tmo_cycle", 66'(first), 66'(16));
    chk("tmo_code", 66'(err_code), 66'(2'b10));
    cycle(1, 8'h00, 0);
    cycle(1, 8'hFF, 0);
    build(8'h03, 32'hA5A5A5A5, 32'h000000A5, 0);
    send(0, 0);
    chk("garbage_valid", 66'(cmd_valid), 66'(1));
    chk("garbage_word", cmd_word, {32'h000000A5, 32'hA5A5A5A5, 2'b11});
    cycle(0, 8'h00, 1);

    cycle(1, HDR, 0);
    repeat (TMO - 1) cycle(0, 8'h00, 0);
    cycle(1, 8'h00, 0);
    chk("byte_wins_err", 66'(frame_err), 66'(0));
    repeat (TMO) cycle(0, 8'h00, 0);
    chk("byte_wins_later_code", 66'(err_code), 66'(2'b10));

    build(8'h01, 32'h3F800000, 32'h40000000, 0);
    send(0, 0);
    ovn = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(i % 7 == 3, 8'h5A, 0);
      if (overrun) ovn++;
    end
    chk("bp_overruns", 66'(ovn), 66'(3));
    chk("bp_valid", 66'(cmd_valid), 66'(1));
    chk("bp_word", cmd_word, {32'h40000000, 32'h3F800000, 2'b01});
    cycle(0, 8'h00, 1);
    chk("bp_release", 66'(cmd_valid), 66'(0));

    build(8'h02, 32'h40000000, 32'h40800000, 0);
    for (int i = 0; i < 5; i++) cycle(1, tx[i], 0);
    do_reset();
    repeat (3) cycle(0, 8'h00, 1);
    send(1, 0);
    chk("post_rst_word", cmd_word, {32'h40800000, 32'h40000000, 2'b10});
    chk("post_rst_valid", 66'(cmd_valid), 66'(1));
    do_reset();
    repeat (4) cycle(0, 8'h00, 1);

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a[15:8] = HDR;
      opb = kind == 7 ? {6'($urandom_range(1, 63)), 2'($urandom)} : {6'b0, 2'($urandom)};
      gap = $urandom_range(0, 7) == 0 ? TMO - 1 : $urandom_range(0, 2);
      if (kind == 8) begin
        repeat ($urandom_range(1, 3)) cycle(1, 8'($urandom_range(0, 164)), 0);
      end else begin
        build(opb, a, b, kind == 6);
        if (kind == 9) begin
          k = $urandom_range(1, 10);
          while (tx.size() > k) tx.pop_back();
          send(gap, 0);
          repeat (TMO + 2) cycle(0, 8'h00, 0);
        end else send(gap, $urandom_range(0, 1));
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_assembler.md
UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, sets the idle cycles allowed between bytes inside a frame before the frame is aborted.
REQ-002 Parameter HEADER, default 8'hA5, is the sync byte that opens a frame.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received UART byte, valid only when rx_valid=1.
REQ-006 rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 cmd_word  output  66  command {B[31:0], A[31:0], op[1:0]} for the downstream FP state machine's uart_in.
REQ-008 cmd_valid  output  1  cmd_word holds a complete, checked command.
REQ-009 cmd_ready  input  1  downstream accepts cmd_word; driven from the downstream done.
REQ-010 frame_err  output  1  one-cycle pulse on a frame abort.
REQ-011 err_code  output  2  cause of the last abort: 01 checksum, 10 timeout, 11 bad opcode byte; held until the next abort.
REQ-012 overrun  output  1  one-cycle pulse when a byte is dropped in HOLD.

Function
REQ-013 Frame format: HEADER, OP byte, A bytes 3..0 (MSB first), B bytes 3..0 (MSB first), CHK byte. Total 11 bytes.
REQ-014 OP byte bits[7:2] SHALL be 0; op = bits[1:0].
REQ-015 CHK SHALL equal the XOR of the OP byte and the 8 operand bytes.
REQ-016 FSM states: IDLE, OPCODE, PAYLOAD, CHECK, HOLD.
- IDLE: HEADER goes to OPCODE; any other byte is ignored silently.
REQ-017 OPCODE transitions:
- Valid OP byte: go to PAYLOAD.
- OP byte with bits[7:2] != 0: abort with err_code 11, go to IDLE.
REQ-018 PAYLOAD: a 3-bit byte counter shifts the 8 operand bytes into A, then B; the 8th byte goes to CHECK.
REQ-019 CHECK transitions:
- CHK matches: load cmd_word, go to HOLD.
- CHK mismatches: abort with err_code 01, go to IDLE.
REQ-020 Latency: cmd_valid SHALL rise on the cycle after the cycle in which the CHK byte is sampled.
REQ-021 HOLD:
- cmd_valid=1 and cmd_word stays stable until cmd_valid&&cmd_ready.
- cmd_valid falls the next cycle and the FSM returns to IDLE.
REQ-022 Any rx_valid in HOLD, including the handshake cycle, SHALL drop the byte and pulse overrun.
REQ-023 Timeout counter behaviour:
- Runs only in OPCODE, PAYLOAD and CHECK.
- Clears on every accepted byte and on entry to IDLE.
- At TIMEOUT_CYCLES-1 without rx_valid: abort with err_code 10, go to IDLE.
REQ-024 If rx_valid and timeout expiry occur in the same cycle, the byte SHALL win: it is accepted and the counter cleared.
REQ-025 An abort SHALL never assert cmd_valid, and cmd_word SHALL retain its previous value.
REQ-026 A HEADER byte received mid-frame SHALL be treated as data, not as a resync.

Reset
REQ-027 While reset=0, all of the following SHALL be cleared immediately: FSM to IDLE, cmd_word 0, cmd_valid 0, frame_err 0, err_code 00, overrun 0, counters 0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending command; no cmd_valid may follow the deassertion.

Structure
REQ-029 Package uart_cmd_pkg SHALL hold:
- the FSM state enum;
- the default HEADER;
- FRAME_LEN=11;
- the err_code constants ERR_CHK, ERR_TMO, ERR_OP.
REQ-030 The inter-byte timer SHALL be the one sub-module, byte_timeout_timer (inputs clear and enable; output expired).

Verification
REQ-031 Good frame: bytes A5 00 40 A0 00 00 40 40 00 00 E0, then cmd_ready pulses -> cmd_valid one cycle after E0, cmd_word={32'h40400000,32'h40A00000,2'b00}, frame_err never pulses.
REQ-032 Bad checksum: same frame with CHK=FF -> frame_err one pulse, err_code=01, cmd_valid stays 0; a following good frame is accepted.
REQ-033 Timeout: TIMEOUT_CYCLES=16; send A5 01 41, then idle 20 cycles -> frame_err with err_code=10 at the 16th idle cycle; leading garbage bytes 00 FF before a good frame are ignored.
REQ-034 Back-pressure: hold cmd_ready=0 for 20 cycles after a good frame and send 3 bytes -> 3 overrun pulses, cmd_word unchanged, accepted on cmd_ready=1.
REQ-035 Reset mid-payload: reset=0 after 5 bytes -> all outputs 0 at once; after release, a good frame with op=10, A=40000000, B=40800000 yields cmd_word={32'h40800000,32'h40000000,2'b10}.
REQ-036 Bad opcode byte 0x07 after the header -> err_code=11, FSM in IDLE.
